reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the processor's single-port register file.
- Adds:
  - configurable data width and register count
  - two independent combinational read ports
  - optional write-to-read bypass
  - a dedicated $dst tap at a configurable index
  - a multi-cycle "sweep clear" sequencer that zeroes the array one entry per cycle under a ready/busy handshake
- Sits between decode (register indices) and the ALU/datapath (operands, result writeback).

Parameters:
- DATA_W, 8, width of each register in bits
- ADDR_W, 4, register index width
- NUM_REGS, 16, number of registers; must satisfy 2 <= NUM_REGS <= 2**ADDR_W
- DST_IDX, 15, register index exported on dst_out; must be < NUM_REGS
- BYPASS, 1, 1 = a read of the address being written returns wr_data in the same cycle; 0 = read returns the stored value

Ports:
- CLK  input  1  clock; all state updates on posedge
- RESET  input  1  asynchronous, active-high reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write index
- wr_data  input  DATA_W  write data
- wr_ready  output  1  1 = write requests are accepted this cycle
- rd_a_addr  input  ADDR_W  read port A index
- rd_a_data  output  DATA_W  read port A data (combinational)
- rd_b_addr  input  ADDR_W  read port B index
- rd_b_data  output  DATA_W  read port B data (combinational)
- dst_out  output  DATA_W  contents of register DST_IDX (combinational from storage, never bypassed)
- clr_start  input  1  request a sweep clear
- clr_busy  output  1  sweep clear in progress
- clr_done  output  1  one-cycle pulse on completion of a sweep
- wr_err  output  1  registered one-cycle pulse: last cycle's write was dropped

Behaviour:
- Reset (async, RESET=1):
  - all NUM_REGS registers = 0; FSM = IDLE; clear cursor = 0
  - clr_busy=0, clr_done=0, wr_err=0, wr_ready=1
  - all read outputs therefore = 0
  - Reset asserted mid-sweep aborts the sweep immediately; no clr_done is produced.
- Write (state IDLE):
  - wr_en=1, wr_ready=1, wr_addr < NUM_REGS -> register written at the posedge.
  - wr_addr >= NUM_REGS -> write dropped, wr_err=1 next cycle.
- Reads:
  - rd_x_data = register[rd_x_addr].
  - rd_x_addr >= NUM_REGS -> rd_x_data = 0.
  - BYPASS=1 and an accepted write (wr_en & wr_ready & in-range) with wr_addr == rd_x_addr -> rd_x_data = wr_data in that same cycle.
  - Both ports may read the same address.
- FSM states:
  - IDLE: wr_ready=1, clr_busy=0.
    - clr_start=1 -> CLEAR, cursor=0.
    - A write in the same cycle as clr_start is accepted and performed at that posedge.
  - CLEAR: wr_ready=0, clr_busy=1.
    - Each posedge: register[cursor] <= 0, then cursor++.
    - When cursor == NUM_REGS-1 is cleared -> DONE.
    - Duration: exactly NUM_REGS cycles.
    - Any wr_en=1 while in CLEAR is dropped and produces wr_err=1 the following cycle.
    - clr_start while in CLEAR is ignored and does not restart the sweep.
  - DONE: one cycle; clr_done=1, clr_busy=0, wr_ready=1; writes are accepted; next state is IDLE.
    - clr_start=1 in DONE -> CLEAR (back-to-back sweep).
- Reads remain valid throughout CLEAR and return partially cleared contents.
- Cursor width = ADDR_W. Cursor wrap is never reached because the FSM exits at NUM_REGS-1.
- wr_err is registered; it is high for exactly one cycle per dropped write.

Test Plan:
- Reset then write 22 to r0, 13 to r2, 187 to r0 on successive cycles -> rd_a(r0)=187, rd_b(r2)=13; all other registers read 0.
- BYPASS=1: r3 holds 5; write 99 to r3 while rd_a_addr=3 -> rd_a_data=99 in the same cycle. With BYPASS=0, same stimulus -> 5 that cycle, 99 next cycle.
- Write 0xA5 to r15 -> dst_out=0xA5 one cycle after the write edge. rd_b_addr=15 with a concurrent write of 0x3C -> rd_b_data=0x3C while dst_out stays 0xA5.
- Fill r0..r15 with their index + 1, pulse clr_start:
  - clr_busy high for exactly 16 cycles, then clr_done high for 1 cycle
  - mid-sweep (after 8 cycles) r0..r7=0 and r8=9
  - final state: all registers 0
- Assert wr_en (r4 <= 77) during CLEAR -> write ignored, wr_err=1 next cycle, r4=0 after the sweep. Assert clr_start mid-sweep -> total sweep length still 16.
- NUM_REGS=12 instance:
  - write to address 13 -> wr_err pulse, no storage change
  - rd_a_addr=13 -> 0
  - sweep lasts 12 cycles
- Separately, assert RESET mid-sweep -> clr_busy drops immediately, no clr_done, all registers 0.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write port, two read ports, dst tap, sweep-clear control and FSM debug.
// Handshake: a write transfers at a posedge when wr_en && wr_ready; a write with wr_ready low or an out-of-range index is dropped and flagged on wr_err.
interface reg_file_mp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [DATA_W-1:0] rd_a_data;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] rd_b_data;
    logic [DATA_W-1:0] dst_out;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              wr_err;
    logic [1:0]        dbg_state;

    modport master (
        output wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr, clr_start,
        input  wr_ready, rd_a_data, rd_b_data, dst_out, clr_busy, clr_done, wr_err, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr, clr_start,
        output wr_ready, rd_a_data, rd_b_data, dst_out, clr_busy, clr_done, wr_err, dbg_state
    );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with optional write bypass, dst tap,
// and a one-entry-per-cycle sweep-clear sequencer.
module reg_file_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int DST_IDX  = 15,
    parameter int BYPASS   = 1
) (
    input logic          CLK,
    input logic          RESET,
    reg_file_mp_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic              wr_err_q, wr_err_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              wr_ready;
    logic              wr_acc;
    logic [DATA_W-1:0] rd_a, rd_b;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NUM_REGS_X;
    endfunction

    assign wr_ready = (state_q != ST_CLEAR);
    assign wr_acc   = bus.wr_en && wr_ready && in_range(bus.wr_addr);
    assign wr_err_d = bus.wr_en && !wr_acc;

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    state_d  = ST_CLEAR;
                    cursor_d = '0;
                end
            end
            ST_CLEAR: begin
                // clr_start is deliberately not looked at here: a sweep never restarts itself.
                if (cursor_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    cursor_d = cursor_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = bus.clr_start ? ST_CLEAR : ST_IDLE;
                cursor_d = '0;
            end
            default: begin
                state_d  = ST_IDLE;
                cursor_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cursor_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Writes are never accepted in CLEAR, so the sweep and a write cannot collide.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            regs_q[cursor_q] <= '0;
        end else if (wr_acc) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rd_a = '0;
        if (in_range(bus.rd_a_addr)) begin
            rd_a = regs_q[bus.rd_a_addr];
        end
        if (BYPASS != 0 && wr_acc && bus.wr_addr == bus.rd_a_addr) begin
            rd_a = bus.wr_data;
        end
    end

    always_comb begin
        rd_b = '0;
        if (in_range(bus.rd_b_addr)) begin
            rd_b = regs_q[bus.rd_b_addr];
        end
        if (BYPASS != 0 && wr_acc && bus.wr_addr == bus.rd_b_addr) begin
            rd_b = bus.wr_data;
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.rd_a_data = rd_a;
    assign bus.rd_b_data = rd_b;
    assign bus.dst_out   = regs_q[DST_IDX];
    assign bus.clr_busy  = (state_q == ST_CLEAR);
    assign bus.clr_done  = (state_q == ST_DONE);
    assign bus.wr_err    = wr_err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default instance, a no-bypass instance and a 12-entry instance.
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    reg_file_mp_if #(.DATA_W(8), .ADDR_W(4)) ifa ();
    reg_file_mp_if #(.DATA_W(8), .ADDR_W(4)) ifb ();
    reg_file_mp_if #(.DATA_W(8), .ADDR_W(4)) ifc ();

    reg_file_mp #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(16), .DST_IDX(15), .BYPASS(1))
        dut_a (.CLK(clk), .RESET(rst), .bus(ifa.slave));
    reg_file_mp #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(16), .DST_IDX(15), .BYPASS(0))
        dut_b (.CLK(clk), .RESET(rst), .bus(ifb.slave));
    reg_file_mp #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(12), .DST_IDX(11), .BYPASS(1))
        dut_c (.CLK(clk), .RESET(rst), .bus(ifc.slave));

    int n_cmp = 0;
    int n_err = 0;
    int busy_a = 0, done_a = 0, busy_c = 0, done_c = 0;

    always @(negedge clk) begin
        if (ifa.clr_busy === 1'b1) busy_a <= busy_a + 1;
        if (ifa.clr_done === 1'b1) done_a <= done_a + 1;
        if (ifc.clr_busy === 1'b1) busy_c <= busy_c + 1;
        if (ifc.clr_done === 1'b1) done_c <= done_c + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.wr_en = 0; ifa.wr_addr = 0; ifa.wr_data = 0; ifa.rd_a_addr = 0; ifa.rd_b_addr = 0; ifa.clr_start = 0;
        ifb.wr_en = 0; ifb.wr_addr = 0; ifb.wr_data = 0; ifb.rd_a_addr = 0; ifb.rd_b_addr = 0; ifb.clr_start = 0;
        ifc.wr_en = 0; ifc.wr_addr = 0; ifc.wr_data = 0; ifc.rd_a_addr = 0; ifc.rd_b_addr = 0; ifc.clr_start = 0;
    endtask

    task automatic write_a(input logic [3:0] addr, input logic [7:0] data);
        ifa.wr_en = 1; ifa.wr_addr = addr; ifa.wr_data = data;
        tick();
        ifa.wr_en = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_all();
        #3;
        n_cmp++; if (ifa.wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b want 1", ifa.wr_ready); end
        n_cmp++; if (ifa.clr_busy !== 1'b0) begin n_err++; $display("FAIL reset_clr_busy got %b want 0", ifa.clr_busy); end
        n_cmp++; if (ifa.clr_done !== 1'b0) begin n_err++; $display("FAIL reset_clr_done got %b want 0", ifa.clr_done); end
        n_cmp++; if (ifa.wr_err !== 1'b0) begin n_err++; $display("FAIL reset_wr_err got %b want 0", ifa.wr_err); end
        n_cmp++; if (ifa.dst_out !== 8'h00) begin n_err++; $display("FAIL reset_dst got %h want 00", ifa.dst_out); end
        n_cmp++; if (ifa.rd_a_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_a got %h want 00", ifa.rd_a_data); end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_write_read();
        write_a(4'd0, 8'd22);
        write_a(4'd2, 8'd13);
        write_a(4'd0, 8'd187);
        ifa.rd_a_addr = 0; ifa.rd_b_addr = 2;
        #1;
        n_cmp++; if (ifa.rd_a_data !== 8'd187) begin n_err++; $display("FAIL wr_rd_r0 got %0d want 187", ifa.rd_a_data); end
        n_cmp++; if (ifa.rd_b_data !== 8'd13) begin n_err++; $display("FAIL wr_rd_r2 got %0d want 13", ifa.rd_b_data); end
        for (int i = 1; i < 16; i++) begin
            if (i != 2) begin
                ifa.rd_a_addr = 4'(i);
                #1;
                n_cmp++; if (ifa.rd_a_data !== 8'd0) begin n_err++; $display("FAIL wr_rd_other r%0d got %0d want 0", i, ifa.rd_a_data); end
            end
        end
    endtask

    task automatic test_bypass();
        ifa.wr_en = 1; ifa.wr_addr = 3; ifa.wr_data = 5;
        ifb.wr_en = 1; ifb.wr_addr = 3; ifb.wr_data = 5;
        tick();
        ifa.wr_data = 99; ifa.rd_a_addr = 3;
        ifb.wr_data = 99; ifb.rd_a_addr = 3;
        #1;
        n_cmp++; if (ifa.rd_a_data !== 8'd99) begin n_err++; $display("FAIL bypass_on got %0d want 99", ifa.rd_a_data); end
        n_cmp++; if (ifb.rd_a_data !== 8'd5) begin n_err++; $display("FAIL bypass_off_same got %0d want 5", ifb.rd_a_data); end
        tick();
        ifa.wr_en = 0; ifb.wr_en = 0;
        #1;
        n_cmp++; if (ifb.rd_a_data !== 8'd99) begin n_err++; $display("FAIL bypass_off_next got %0d want 99", ifb.rd_a_data); end
        n_cmp++; if (ifa.rd_a_data !== 8'd99) begin n_err++; $display("FAIL bypass_on_next got %0d want 99", ifa.rd_a_data); end
    endtask

    task automatic test_dst();
        write_a(4'd15, 8'hA5);
        n_cmp++; if (ifa.dst_out !== 8'hA5) begin n_err++; $display("FAIL dst_after_write got %h want a5", ifa.dst_out); end
        ifa.rd_b_addr = 15; ifa.wr_en = 1; ifa.wr_addr = 15; ifa.wr_data = 8'h3C;
        #1;
        n_cmp++; if (ifa.rd_b_data !== 8'h3C) begin n_err++; $display("FAIL dst_rd_b_bypass got %h want 3c", ifa.rd_b_data); end
        n_cmp++; if (ifa.dst_out !== 8'hA5) begin n_err++; $display("FAIL dst_not_bypassed got %h want a5", ifa.dst_out); end
        tick();
        ifa.wr_en = 0;
        n_cmp++; if (ifa.dst_out !== 8'h3C) begin n_err++; $display("FAIL dst_updated got %h want 3c", ifa.dst_out); end
    endtask

    task automatic test_sweep();
        int b0, d0;
        for (int i = 0; i < 16; i++) write_a(4'(i), 8'(i + 1));
        b0 = busy_a; d0 = done_a;
        ifa.clr_start = 1;
        tick();
        ifa.clr_start = 0;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            ifa.rd_a_addr = 4'(i); ifa.rd_b_addr = 4'(i + 8);
            #1;
            n_cmp++; if (ifa.rd_a_data !== 8'd0) begin n_err++; $display("FAIL sweep_mid_low r%0d got %0d want 0", i, ifa.rd_a_data); end
            n_cmp++; if (ifa.rd_b_data !== 8'(i + 9)) begin n_err++; $display("FAIL sweep_mid_high r%0d got %0d want %0d", i + 8, ifa.rd_b_data, i + 9); end
        end
        for (int k = 0; k < 40 && done_a == d0; k++) tick();
        repeat (3) tick();
        n_cmp++; if (busy_a - b0 !== 16) begin n_err++; $display("FAIL sweep_busy_cycles got %0d want 16", busy_a - b0); end
        n_cmp++; if (done_a - d0 !== 1) begin n_err++; $display("FAIL sweep_done_pulses got %0d want 1", done_a - d0); end
        n_cmp++; if (ifa.wr_ready !== 1'b1) begin n_err++; $display("FAIL sweep_ready_after got %b want 1", ifa.wr_ready); end
        for (int i = 0; i < 16; i++) begin
            ifa.rd_a_addr = 4'(i);
            #1;
            n_cmp++; if (ifa.rd_a_data !== 8'd0) begin n_err++; $display("FAIL sweep_final r%0d got %0d want 0", i, ifa.rd_a_data); end
        end
    endtask

    task automatic test_clear_write();
        int b0, d0;
        write_a(4'd4, 8'd44);
        b0 = busy_a; d0 = done_a;
        ifa.clr_start = 1;
        tick();
        ifa.clr_start = 0;
        repeat (10) tick();
        ifa.wr_en = 1; ifa.wr_addr = 4; ifa.wr_data = 77; ifa.clr_start = 1;
        #1;
        n_cmp++; if (ifa.wr_ready !== 1'b0) begin n_err++; $display("FAIL clr_wr_ready got %b want 0", ifa.wr_ready); end
        n_cmp++; if (ifa.wr_err !== 1'b0) begin n_err++; $display("FAIL clr_err_before got %b want 0", ifa.wr_err); end
        tick();
        ifa.wr_en = 0; ifa.clr_start = 0;
        n_cmp++; if (ifa.wr_err !== 1'b1) begin n_err++; $display("FAIL clr_err_pulse got %b want 1", ifa.wr_err); end
        tick();
        n_cmp++; if (ifa.wr_err !== 1'b0) begin n_err++; $display("FAIL clr_err_single got %b want 0", ifa.wr_err); end
        for (int k = 0; k < 40 && done_a == d0; k++) tick();
        repeat (3) tick();
        n_cmp++; if (busy_a - b0 !== 16) begin n_err++; $display("FAIL clr_restart_len got %0d want 16", busy_a - b0); end
        n_cmp++; if (done_a - d0 !== 1) begin n_err++; $display("FAIL clr_restart_done got %0d want 1", done_a - d0); end
        ifa.rd_a_addr = 4;
        #1;
        n_cmp++; if (ifa.rd_a_data !== 8'd0) begin n_err++; $display("FAIL clr_r4 got %0d want 0", ifa.rd_a_data); end
    endtask

    task automatic test_small();
        int b0, d0;
        ifc.wr_en = 1; ifc.wr_addr = 1; ifc.wr_data = 8'h11;
        tick();
        n_cmp++; if (ifc.wr_err !== 1'b0) begin n_err++; $display("FAIL small_valid_err got %b want 0", ifc.wr_err); end
        ifc.wr_addr = 13; ifc.wr_data = 8'h55; ifc.rd_a_addr = 13; ifc.rd_b_addr = 1;
        #1;
        n_cmp++; if (ifc.rd_a_data !== 8'h00) begin n_err++; $display("FAIL small_oor_no_bypass got %h want 00", ifc.rd_a_data); end
        tick();
        ifc.wr_en = 0;
        n_cmp++; if (ifc.wr_err !== 1'b1) begin n_err++; $display("FAIL small_oor_err got %b want 1", ifc.wr_err); end
        n_cmp++; if (ifc.rd_a_data !== 8'h00) begin n_err++; $display("FAIL small_oor_read got %h want 00", ifc.rd_a_data); end
        n_cmp++; if (ifc.rd_b_data !== 8'h11) begin n_err++; $display("FAIL small_r1 got %h want 11", ifc.rd_b_data); end
        tick();
        n_cmp++; if (ifc.wr_err !== 1'b0) begin n_err++; $display("FAIL small_err_single got %b want 0", ifc.wr_err); end
        b0 = busy_c; d0 = done_c;
        ifc.clr_start = 1;
        tick();
        ifc.clr_start = 0;
        for (int k = 0; k < 40 && done_c == d0; k++) tick();
        repeat (3) tick();
        n_cmp++; if (busy_c - b0 !== 12) begin n_err++; $display("FAIL small_sweep_len got %0d want 12", busy_c - b0); end
        n_cmp++; if (done_c - d0 !== 1) begin n_err++; $display("FAIL small_sweep_done got %0d want 1", done_c - d0); end
        n_cmp++; if (ifc.rd_b_data !== 8'h00) begin n_err++; $display("FAIL small_r1_cleared got %h want 00", ifc.rd_b_data); end
    endtask

    task automatic test_reset_mid_sweep();
        int d0;
        write_a(4'd5, 8'h55);
        write_a(4'd9, 8'h99);
        ifa.rd_a_addr = 9; ifa.rd_b_addr = 5;
        d0 = done_a;
        ifa.clr_start = 1;
        tick();
        ifa.clr_start = 0;
        repeat (3) tick();
        n_cmp++; if (ifa.clr_busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before got %b want 1", ifa.clr_busy); end
        rst = 1;
        #1;
        n_cmp++; if (ifa.clr_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", ifa.clr_busy); end
        n_cmp++; if (ifa.clr_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", ifa.clr_done); end
        n_cmp++; if (ifa.rd_a_data !== 8'h00) begin n_err++; $display("FAIL rstmid_r9 got %h want 00", ifa.rd_a_data); end
        n_cmp++; if (ifa.rd_b_data !== 8'h00) begin n_err++; $display("FAIL rstmid_r5 got %h want 00", ifa.rd_b_data); end
        tick();
        rst = 0;
        repeat (20) tick();
        n_cmp++; if (done_a - d0 !== 0) begin n_err++; $display("FAIL rstmid_no_done got %0d want 0", done_a - d0); end
        n_cmp++; if (ifa.wr_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", ifa.wr_ready); end
        n_cmp++; if (ifa.clr_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle got %b want 0", ifa.clr_busy); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_dst();
        test_sweep();
        test_clear_write();
        test_small();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
